// File: rtl/bolo_row_buffer_pkg.sv
// Shared types and defaults for the bolometer ping-pong row buffer.
// The FSM encoding is shared with the UART frame transmitter.
package bolo_row_buffer_pkg;

    localparam int unsigned PIX_IN_ROW_DEF = 384;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } buf_state_t;

    // Widens an ADC sample to the transmitter word by zero-extension.
    function automatic logic [15:0] pix_word(input logic [15:0] sample);
        return sample;
    endfunction

endpackage

// File: rtl/bolo_row_buffer_row_bank_ram.sv
// Two-bank simple dual-port row RAM: one write port and one registered read port.
// Writing and reading the same word in one cycle returns the old contents.
module row_bank_ram #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 14
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W:0]   wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W:0]   rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    localparam int unsigned DEPTH = 2 * (2 ** ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/bolo_row_buffer.sv
// Ping-pong row store between the bolometer ADC and the UART frame transmitter:
// captures a row into the write bank while the transmitter reads the other bank.
module bolo_row_buffer
    import bolo_row_buffer_pkg::*;
#(
    parameter int unsigned PIX_IN_ROW = PIX_IN_ROW_DEF,
    parameter int unsigned ADC_W      = 14,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic              CLK_UART,
    input  logic              RESET,
    input  logic [ADC_W-1:0]  ADC_DATA,
    input  logic              ADC_VALID,
    input  logic              READ_IN_EN,
    input  logic              BUF_CHANGE,
    input  logic              BUFER_EN,
    input  logic [ADDR_W-1:0] CNT_PIX_OUT,
    output logic [15:0]       VALUE,
    output logic              ROW_READY,
    output logic              CAPTURING,
    output logic [ADC_W-1:0]  ROW_MIN,
    output logic [ADC_W-1:0]  ROW_MAX,
    output logic              OVERRUN,
    output logic              TIMEOUT_ERR
);
    localparam int unsigned       IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_IN_ROW - 1);
    localparam logic [ADDR_W:0]   PIX_LIMIT = (ADDR_W + 1)'(PIX_IN_ROW);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    buf_state_t        state_q;
    buf_state_t        state_d;
    logic              start_cap;
    logic              wr_en;
    logic              set_overrun;
    logic              set_timeout;
    logic              load_minmax;
    logic              set_pending;
    logic              pending_q;
    logic              wr_bank_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [IDLE_W-1:0] idle_cnt_q;
    logic [ADC_W-1:0]  acc_min_q;
    logic [ADC_W-1:0]  acc_max_q;
    logic              rd_en_q;
    logic [ADC_W-1:0]  ram_rd_data;

    always_ff @(posedge CLK_UART or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A start request seen during DONE is parked in pending_q and honoured from IDLE.
    always_comb begin
        state_d     = state_q;
        start_cap   = 1'b0;
        wr_en       = 1'b0;
        set_overrun = 1'b0;
        set_timeout = 1'b0;
        load_minmax = 1'b0;
        set_pending = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (READ_IN_EN || pending_q) begin
                    start_cap = 1'b1;
                    state_d   = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (READ_IN_EN) begin
                    start_cap   = 1'b1;
                    set_overrun = 1'b1;
                end else if (ADC_VALID) begin
                    wr_en = 1'b1;
                    if (wr_addr_q == LAST_ADDR) begin
                        state_d = ST_DONE;
                    end
                end else if (idle_cnt_q == IDLE_LAST) begin
                    set_timeout = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_DONE: begin
                load_minmax = 1'b1;
                set_pending = READ_IN_EN;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_UART or posedge RESET) begin
        if (RESET) begin
            wr_bank_q  <= 1'b0;
            wr_addr_q  <= '0;
            idle_cnt_q <= '0;
            acc_min_q  <= '0;
            acc_max_q  <= '0;
        end else if (start_cap) begin
            wr_bank_q  <= ~BUF_CHANGE;
            wr_addr_q  <= '0;
            idle_cnt_q <= '0;
            acc_min_q  <= '1;
            acc_max_q  <= '0;
        end else if (wr_en) begin
            wr_addr_q  <= wr_addr_q + 1'b1;
            idle_cnt_q <= '0;
            if (ADC_DATA < acc_min_q) begin
                acc_min_q <= ADC_DATA;
            end
            if (ADC_DATA > acc_max_q) begin
                acc_max_q <= ADC_DATA;
            end
        end else if (state_q == ST_CAPTURE) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK_UART or posedge RESET) begin
        if (RESET) begin
            pending_q   <= 1'b0;
            OVERRUN     <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
            ROW_MIN     <= '0;
            ROW_MAX     <= '0;
            rd_en_q     <= 1'b0;
        end else begin
            if (set_pending) begin
                pending_q <= 1'b1;
            end else if (start_cap) begin
                pending_q <= 1'b0;
            end
            if (set_overrun) begin
                OVERRUN <= 1'b1;
            end
            if (set_timeout) begin
                TIMEOUT_ERR <= 1'b1;
            end
            if (load_minmax) begin
                ROW_MIN <= acc_min_q;
                ROW_MAX <= acc_max_q;
            end
            rd_en_q <= BUFER_EN && ({1'b0, CNT_PIX_OUT} < PIX_LIMIT);
        end
    end

    row_bank_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (ADC_W)
    ) u_row_bank_ram (
        .clk     (CLK_UART),
        .we      (wr_en),
        .wr_addr ({wr_bank_q, wr_addr_q}),
        .wr_data (ADC_DATA),
        .rd_addr ({BUF_CHANGE, CNT_PIX_OUT}),
        .rd_data (ram_rd_data)
    );

    always_comb begin
        VALUE     = rd_en_q ? pix_word(16'(ram_rd_data)) : '0;
        ROW_READY = (state_q == ST_DONE);
        CAPTURING = (state_q == ST_CAPTURE);
    end

endmodule

// File: tb/tb_bolo_row_buffer.sv
// Directed bench for bolo_row_buffer: table-driven read checks plus
// hand-written capture, overrun, timeout and reset sequences.
module tb_bolo_row_buffer;

    logic        CLK_UART = 1'b0;
    logic        RESET;
    logic [13:0] ADC_DATA;
    logic        ADC_VALID;
    logic        READ_IN_EN;
    logic        BUF_CHANGE;
    logic        BUFER_EN;
    logic [9:0]  CNT_PIX_OUT;
    logic [15:0] VALUE;
    logic        ROW_READY;
    logic        CAPTURING;
    logic [13:0] ROW_MIN;
    logic [13:0] ROW_MAX;
    logic        OVERRUN;
    logic        TIMEOUT_ERR;

    int n_assert = 0;
    int n_fail   = 0;
    int rr_cnt   = 0;
    int rr_base;
    int n_idle;

    typedef struct {
        string    name;
        bit       en;
        bit [9:0] cnt;
        int       exp;
    } rd_vec_t;

    rd_vec_t rd_vecs[10];

    bolo_row_buffer #(
        .PIX_IN_ROW (384),
        .ADC_W      (14),
        .ADDR_W     (10),
        .TIMEOUT    (4096)
    ) dut (
        .CLK_UART    (CLK_UART),
        .RESET       (RESET),
        .ADC_DATA    (ADC_DATA),
        .ADC_VALID   (ADC_VALID),
        .READ_IN_EN  (READ_IN_EN),
        .BUF_CHANGE  (BUF_CHANGE),
        .BUFER_EN    (BUFER_EN),
        .CNT_PIX_OUT (CNT_PIX_OUT),
        .VALUE       (VALUE),
        .ROW_READY   (ROW_READY),
        .CAPTURING   (CAPTURING),
        .ROW_MIN     (ROW_MIN),
        .ROW_MAX     (ROW_MAX),
        .OVERRUN     (OVERRUN),
        .TIMEOUT_ERR (TIMEOUT_ERR)
    );

    always #5 CLK_UART = ~CLK_UART;

    always @(posedge CLK_UART) begin
        if (ROW_READY === 1'b1) rr_cnt <= rr_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK_UART);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start_cap();
        READ_IN_EN = 1'b1;
        tick();
        READ_IN_EN = 1'b0;
    endtask

    task automatic read_chk(input string name, input bit bank, input int cnt, input int exp);
        BUF_CHANGE  = bank;
        BUFER_EN    = 1'b1;
        CNT_PIX_OUT = 10'(cnt);
        tick();
        check(name, 32'(VALUE), 32'(exp));
    endtask

    initial begin
        rd_vecs[0] = '{"rd_idx0",   1'b1, 10'd0,    0};
        rd_vecs[1] = '{"rd_idx1",   1'b1, 10'd1,    1};
        rd_vecs[2] = '{"rd_idx100", 1'b1, 10'd100,  100};
        rd_vecs[3] = '{"rd_idx255", 1'b1, 10'd255,  255};
        rd_vecs[4] = '{"rd_idx383", 1'b1, 10'd383,  383};
        rd_vecs[5] = '{"rd_idx384", 1'b1, 10'd384,  0};
        rd_vecs[6] = '{"rd_idx400", 1'b1, 10'd400,  0};
        rd_vecs[7] = '{"rd_idx1023",1'b1, 10'd1023, 0};
        rd_vecs[8] = '{"rd_dis5",   1'b0, 10'd5,    0};
        rd_vecs[9] = '{"rd_idx382", 1'b1, 10'd382,  382};

        RESET = 1'b1; ADC_DATA = '0; ADC_VALID = 1'b0; READ_IN_EN = 1'b0;
        BUF_CHANGE = 1'b0; BUFER_EN = 1'b0; CNT_PIX_OUT = '0;
        repeat (3) tick();
        check("rst_value", 32'(VALUE), 0);
        check("rst_row_ready", 32'(ROW_READY), 0);
        check("rst_capturing", 32'(CAPTURING), 0);
        check("rst_min", 32'(ROW_MIN), 0);
        check("rst_max", 32'(ROW_MAX), 0);
        check("rst_overrun", 32'(OVERRUN), 0);
        check("rst_timeout", 32'(TIMEOUT_ERR), 0);
        RESET = 1'b0;
        tick();

        // 1: full row 0..383 into bank 1
        start_cap();
        check("t1_capturing", 32'(CAPTURING), 1);
        rr_base = rr_cnt;
        for (int i = 0; i < 384; i++) begin
            ADC_VALID = 1'b1; ADC_DATA = 14'(i);
            tick();
            if (i == 382) check("t1_no_early_ready", 32'(ROW_READY), 0);
        end
        ADC_VALID = 1'b0;
        check("t1_row_ready", 32'(ROW_READY), 1);
        tick();
        check("t1_ready_once", 32'(rr_cnt - rr_base), 1);
        check("t1_ready_drop", 32'(ROW_READY), 0);
        check("t1_min", 32'(ROW_MIN), 0);
        check("t1_max", 32'(ROW_MAX), 383);
        check("t1_idle", 32'(CAPTURING), 0);

        // 2: read bank 1 through the vector table, then a full sweep
        BUF_CHANGE = 1'b1;
        for (int k = 0; k < 10; k++) begin
            BUFER_EN = rd_vecs[k].en; CNT_PIX_OUT = rd_vecs[k].cnt;
            tick();
            check(rd_vecs[k].name, 32'(VALUE), 32'(rd_vecs[k].exp));
        end
        BUFER_EN = 1'b1;
        for (int i = 0; i < 384; i++) begin
            CNT_PIX_OUT = 10'(i);
            tick();
            check("t2_sweep", 32'(VALUE), 32'(i));
        end
        CNT_PIX_OUT = 10'd50;
        tick();
        CNT_PIX_OUT = 10'd60;
        #2;
        check("t2_latency_hold", 32'(VALUE), 50);
        tick();
        check("t2_latency_next", 32'(VALUE), 60);

        // 3: capture into bank 0 while sweeping bank 1
        start_cap();
        for (int i = 0; i < 384; i++) begin
            ADC_VALID = 1'b1; ADC_DATA = 14'(1000 + i); CNT_PIX_OUT = 10'(i);
            tick();
            check("t3_bank1_stable", 32'(VALUE), 32'(i));
        end
        check("t3_row_ready", 32'(ROW_READY), 1);
        // READ_IN_EN during DONE: deferred start, no overrun
        ADC_VALID = 1'b0; READ_IN_EN = 1'b1; BUF_CHANGE = 1'b0;
        tick();
        READ_IN_EN = 1'b0;
        check("t3_done_to_idle", 32'(CAPTURING), 0);
        check("t3_min", 32'(ROW_MIN), 1000);
        check("t3_max", 32'(ROW_MAX), 1383);
        tick();
        check("t3_deferred_start", 32'(CAPTURING), 1);
        check("t3_no_overrun", 32'(OVERRUN), 0);

        // 4: restart after 100 samples (writes to bank 1)
        for (int i = 0; i < 100; i++) begin
            ADC_VALID = 1'b1; ADC_DATA = 14'(5000 + i);
            tick();
        end
        ADC_VALID = 1'b0;
        start_cap();
        check("t4_overrun", 32'(OVERRUN), 1);
        check("t4_still_capturing", 32'(CAPTURING), 1);
        rr_base = rr_cnt;
        for (int i = 0; i < 384; i++) begin
            ADC_VALID = 1'b1; ADC_DATA = 14'(2000 + i);
            tick();
            if (i == 382) begin
                check("t4_no_early_ready", 32'(ROW_READY), 0);
                check("t4_no_early_count", 32'(rr_cnt - rr_base), 0);
            end
        end
        ADC_VALID = 1'b0;
        check("t4_row_ready", 32'(ROW_READY), 1);
        tick();
        check("t4_min", 32'(ROW_MIN), 2000);
        check("t4_max", 32'(ROW_MAX), 2383);
        read_chk("t4_bank1_0", 1'b1, 0, 2000);
        read_chk("t4_bank1_99", 1'b1, 99, 2099);
        read_chk("t4_bank1_383", 1'b1, 383, 2383);
        read_chk("t4_bank0_0", 1'b0, 0, 1000);
        read_chk("t4_bank0_383", 1'b0, 383, 1383);

        // 5: timeout after 10 samples into bank 0
        BUF_CHANGE = 1'b1;
        ADC_VALID = 1'b1; ADC_DATA = 14'd9999;
        tick();
        rr_base = rr_cnt;
        READ_IN_EN = 1'b1;
        tick();
        READ_IN_EN = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ADC_VALID = 1'b1; ADC_DATA = 14'(10 + i);
            tick();
        end
        ADC_VALID = 1'b0;
        n_idle = 0;
        while (CAPTURING === 1'b1 && n_idle < 5000) begin
            tick();
            n_idle++;
        end
        check("t5_idle_cycles", 32'(n_idle), 4096);
        check("t5_capturing", 32'(CAPTURING), 0);
        check("t5_timeout_err", 32'(TIMEOUT_ERR), 1);
        check("t5_no_ready", 32'(rr_cnt - rr_base), 0);
        check("t5_min_kept", 32'(ROW_MIN), 2000);
        check("t5_max_kept", 32'(ROW_MAX), 2383);
        read_chk("t5_bank0_0", 1'b0, 0, 10);
        read_chk("t5_bank0_9", 1'b0, 9, 19);
        read_chk("t5_bank0_10", 1'b0, 10, 1010);

        // 6: reset mid-capture, then a clean capture with a mid-row bank toggle
        BUF_CHANGE = 1'b1;
        start_cap();
        for (int i = 0; i < 200; i++) begin
            ADC_VALID = 1'b1; ADC_DATA = 14'(7000 + i);
            tick();
        end
        ADC_VALID = 1'b0;
        RESET = 1'b1;
        #2;
        check("t6_rst_capturing", 32'(CAPTURING), 0);
        check("t6_rst_value", 32'(VALUE), 0);
        check("t6_rst_ready", 32'(ROW_READY), 0);
        check("t6_rst_overrun", 32'(OVERRUN), 0);
        check("t6_rst_timeout", 32'(TIMEOUT_ERR), 0);
        check("t6_rst_min", 32'(ROW_MIN), 0);
        check("t6_rst_max", 32'(ROW_MAX), 0);
        tick();
        RESET = 1'b0;
        tick();
        rr_base = rr_cnt;
        start_cap();
        for (int i = 0; i < 384; i++) begin
            if (i == 192) BUF_CHANGE = 1'b0;
            ADC_VALID = 1'b1; ADC_DATA = 14'(300 + i);
            tick();
        end
        ADC_VALID = 1'b0;
        check("t6_row_ready", 32'(ROW_READY), 1);
        tick();
        check("t6_ready_once", 32'(rr_cnt - rr_base), 1);
        check("t6_min", 32'(ROW_MIN), 300);
        check("t6_max", 32'(ROW_MAX), 683);
        read_chk("t6_bank0_0", 1'b0, 0, 300);
        read_chk("t6_bank0_199", 1'b0, 199, 499);
        read_chk("t6_bank0_300", 1'b0, 300, 600);
        read_chk("t6_bank1_5", 1'b1, 5, 2005);
        read_chk("t6_bank1_300", 1'b1, 300, 2300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
